// File: rtl/gpio_bus_if.sv
// gpio_bus_if: write-request handshake into gpio_bus_master.
// Ports: wr_valid/wr_ready handshake, wr_addr, wr_data (+ wr_word16 with GPIO_MASTER_WORD16_EN).
interface gpio_bus_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
`ifdef GPIO_MASTER_WORD16_EN
  localparam int WD = 2 * DATA_W;
`else
  localparam int WD = DATA_W;
`endif

  logic          wr_valid;
  logic          wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [WD-1:0] wr_data;
`ifdef GPIO_MASTER_WORD16_EN
  logic          wr_word16;

  modport master (
    output wr_valid, wr_addr, wr_data, wr_word16,
    input  wr_ready
  );
  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_word16,
    output wr_ready
  );
`else
  modport master (
    output wr_valid, wr_addr, wr_data,
    input  wr_ready
  );
  modport slave (
    input  wr_valid, wr_addr, wr_data,
    output wr_ready
  );
`endif
endinterface

// File: rtl/gpio_bus_master.sv
// gpio_bus_master: FIFO-buffered serialiser of register writes onto the GPIO word.
// Ports: clk, rst (sync, active-high), bus (gpio_bus_if.slave),
//   gpio_out {7'b0, w_clk, data, addr}, busy, fifo_count, done_pulse.
// Option: GPIO_MASTER_WORD16_EN adds 16-bit entries sent as low byte then high byte.
module gpio_bus_master #(
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 8,
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int SETUP_CYC       = 2,
  parameter int HIGH_CYC        = 2,
  parameter int HOLD_CYC        = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  gpio_bus_if.slave                bus,
  output logic [31:0]              gpio_out,
  output logic                     busy,
  output logic [FIFO_DEPTH_LOG2:0] fifo_count,
  output logic                     done_pulse
);
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam logic [FIFO_DEPTH_LOG2:0] FULL_C =
    (FIFO_DEPTH_LOG2+1)'(DEPTH);
  localparam logic [FIFO_DEPTH_LOG2:0] ONE_C =
    (FIFO_DEPTH_LOG2+1)'(1);
`ifdef GPIO_MASTER_WORD16_EN
  localparam int WD = 2 * DATA_W;
`else
  localparam int WD = DATA_W;
`endif
  localparam logic [7:0] S_LD = 8'(SETUP_CYC - 1);
  localparam logic [7:0] H_LD = 8'(HIGH_CYC - 1);
  localparam logic [7:0] D_LD = 8'(HOLD_CYC - 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WD-1:0]     data;
`ifdef GPIO_MASTER_WORD16_EN
    logic              w16;
`endif
  } entry_t;

  typedef enum logic [1:0] {
    IDLE, SETUP, STROBE, HOLD
  } state_t;

  entry_t mem [DEPTH];
  entry_t in_e;
  entry_t cur;
  logic [FIFO_DEPTH_LOG2-1:0] wptr;
  logic [FIFO_DEPTH_LOG2-1:0] rptr;
  logic [FIFO_DEPTH_LOG2:0]   count;
  logic push;
  logic pop;
  logic have;
  logic last;
  logic more;
  logic w_clk;
  logic [DATA_W-1:0] dbyte;
  logic [7:0] cnt;
  logic [7:0] cnt_n;
  state_t state;
  state_t state_n;

  assign bus.wr_ready = (count != FULL_C);
  assign push = bus.wr_valid & bus.wr_ready;
  assign have = (count != '0);
  assign last = (cnt == 8'd0);
  assign fifo_count = count;
  assign busy = have | (state != IDLE);

  always_comb begin
    in_e      = '0;
    in_e.addr = bus.wr_addr;
    in_e.data = bus.wr_data;
`ifdef GPIO_MASTER_WORD16_EN
    in_e.w16  = bus.wr_word16;
`endif
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= in_e;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + ONE_C;
        2'b01:   count <= count - ONE_C;
        default: count <= count;
      endcase
    end
  end

`ifdef GPIO_MASTER_WORD16_EN
  // hi selects the upper byte for the second write of a 16-bit entry
  logic hi;
  always_ff @(posedge clk) begin
    if (rst) hi <= 1'b0;
    else if (pop) hi <= 1'b0;
    else if (state == HOLD && last && more) hi <= 1'b1;
  end
  assign more  = cur.w16 & ~hi;
  assign dbyte = hi ? cur.data[WD-1:DATA_W]
                    : cur.data[DATA_W-1:0];
`else
  assign more  = 1'b0;
  assign dbyte = cur.data;
`endif

  // state register and output latch
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 8'd0;
      cur   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (pop) cur <= mem[rptr];
    end
  end

  // next state; pop always coincides with entering SETUP
  always_comb begin
    state_n = state;
    cnt_n   = cnt - 8'd1;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = cnt;
        if (have) begin
          pop     = 1'b1;
          state_n = SETUP;
          cnt_n   = S_LD;
        end
      end
      SETUP: begin
        if (last) begin
          state_n = STROBE;
          cnt_n   = H_LD;
        end
      end
      STROBE: begin
        if (last) begin
          state_n = HOLD;
          cnt_n   = D_LD;
        end
      end
      HOLD: begin
        if (last) begin
          if (more) begin
            state_n = SETUP;
            cnt_n   = S_LD;
          end else if (have) begin
            pop     = 1'b1;
            state_n = SETUP;
            cnt_n   = S_LD;
          end else begin
            state_n = IDLE;
            cnt_n   = 8'd0;
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 8'd0;
      end
    endcase
  end

  // outputs
  always_comb begin
    w_clk      = (state == STROBE);
    done_pulse = (state == HOLD) & last & ~more;
  end

  assign gpio_out = 32'({w_clk, dbyte, cur.addr});
endmodule

// File: tb/tb_gpio_bus_master.sv
// tb_gpio_bus_master: directed + random scoreboard bench for gpio_bus_master.
// Receiver model samples fields on each w_clk rise and checks field stability.
module tb_gpio_bus_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] gpio_out;
  logic busy;
  logic [4:0] fifo_count;
  logic done_pulse;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int dones = 0;
  int low_run = 100;
  bit mon_en = 1'b0;
  bit saw_full = 1'b0;
  logic [31:0] prev_g = '0;
  logic [31:0] sbq[$];
  int rise_q[$];

  gpio_bus_if #(.ADDR_W(16), .DATA_W(8)) bus ();

  gpio_bus_master #(
    .ADDR_W(16), .DATA_W(8), .FIFO_DEPTH_LOG2(4),
    .SETUP_CYC(2), .HIGH_CYC(2), .HOLD_CYC(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave),
    .gpio_out(gpio_out),
    .busy(busy),
    .fifo_count(fifo_count),
    .done_pulse(done_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // receiver model
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("ready_vs_full", bus.wr_ready, fifo_count != 5'd16);
      if (fifo_count == 5'd16 && !bus.wr_ready) saw_full = 1'b1;
      if (gpio_out[24] && !prev_g[24]) begin
        rise_q.push_back(cyc);
        if (sbq.size() == 0) begin
          compared++;
          mismatched++;
          $error("FAIL rx_unexpected: observed %0h expected none", gpio_out);
        end else begin
          chk("rx_write", gpio_out, sbq.pop_front());
        end
      end
      if (gpio_out[23:0] != prev_g[23:0])
        chk("field_stable",
            !prev_g[24] && !gpio_out[24] && low_run >= 2, 1'b1);
      low_run = gpio_out[24] ? 0 : low_run + 1;
      if (done_pulse) dones++;
    end
    prev_g = gpio_out;
  end

  task automatic push(input logic [15:0] a,
                      input logic [15:0] d,
                      input bit w16);
    bit acc;
    int n;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = a;
`ifdef GPIO_MASTER_WORD16_EN
    bus.wr_data   = d;
    bus.wr_word16 = w16;
    sbq.push_back({7'd0, 1'b1, d[7:0], a});
    if (w16) sbq.push_back({7'd0, 1'b1, d[15:8], a});
`else
    bus.wr_data = d[7:0];
    sbq.push_back({7'd0, 1'b1, d[7:0], a});
    if (w16) ;
`endif
    n = 0;
    forever begin
      acc = bus.wr_ready;
      tick();
      if (acc) break;
      n++;
      if (n > 200) begin
        chk("push_timeout", n, 0);
        break;
      end
    end
    bus.wr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 2000) begin
      tick();
      n++;
    end
    chk("idle_timeout", busy, 1'b0);
  endtask

  initial begin
    int d0;
    bus.wr_valid = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
`ifdef GPIO_MASTER_WORD16_EN
    bus.wr_word16 = 1'b0;
`endif
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_gpio", gpio_out, 32'h0);
    chk("rst_ready", bus.wr_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_count", fifo_count, 5'd0);
    chk("rst_done", done_pulse, 1'b0);
    mon_en  = 1'b1;
    low_run = 100;

    // single write latency
    d0 = dones;
    push(16'h0024, 16'h00A5, 1'b0);
    tick();
    chk("c2_fields", gpio_out, 32'h00A50024);
    tick();
    chk("c3_setup", gpio_out, 32'h00A50024);
    tick();
    chk("c4_strobe", gpio_out, 32'h01A50024);
    tick();
    chk("c5_strobe", gpio_out, 32'h01A50024);
    tick();
    chk("c6_hold", gpio_out, 32'h00A50024);
    chk("c6_nodone", done_pulse, 1'b0);
    tick();
    chk("c7_done", done_pulse, 1'b1);
    tick();
    chk("c8_busy", busy, 1'b0);
    chk("c8_done", done_pulse, 1'b0);
    chk("single_dones", dones - d0, 1);

    // back-to-back spacing
    rise_q.delete();
    push(16'h000C, 16'h0011, 1'b0);
    push(16'h000D, 16'h0022, 1'b0);
    push(16'h000E, 16'h0033, 1'b0);
    wait_idle();
    chk("b2b_count", rise_q.size(), 3);
    if (rise_q.size() == 3) begin
      chk("b2b_gap1", rise_q[1] - rise_q[0], 6);
      chk("b2b_gap2", rise_q[2] - rise_q[1], 6);
    end

    // fill to full
    d0 = dones;
    for (int i = 0; i < 24; i++)
      push(16'h0100 + 16'(i), 16'(8'(i * 7)), 1'b0);
    wait_idle();
    chk("full_seen", saw_full, 1'b1);
    chk("full_sb_empty", sbq.size(), 0);
    chk("full_dones", dones - d0, 24);

    // reset during strobe
    push(16'h0040, 16'h0077, 1'b0);
    push(16'h0041, 16'h0078, 1'b0);
    begin
      int n;
      n = 0;
      while (!gpio_out[24] && n < 100) begin
        tick();
        n++;
      end
      chk("wait_strobe", gpio_out[24], 1'b1);
    end
    mon_en = 1'b0;
    rst = 1'b1;
    tick();
    chk("rst_mid_gpio", gpio_out, 32'h0);
    chk("rst_mid_count", fifo_count, 5'd0);
    chk("rst_mid_done", done_pulse, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rst_post_done", done_pulse, 1'b0);
      chk("rst_post_gpio", gpio_out, 32'h0);
    end
    sbq.delete();
    low_run = 100;
    mon_en = 1'b1;
    d0 = dones;
    push(16'h0005, 16'h0001, 1'b0);
    wait_idle();
    chk("post_rst_dones", dones - d0, 1);
    chk("post_rst_sb", sbq.size(), 0);
    chk("post_rst_gpio", gpio_out, 32'h00010005);

    // random traffic
    d0 = dones;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      push(16'($urandom), 16'($urandom_range(0, 255)), 1'b0);
    end
    wait_idle();
    chk("rand_sb_empty", sbq.size(), 0);
    chk("rand_dones", dones - d0, 1000);

`ifdef GPIO_MASTER_WORD16_EN
    d0 = dones;
    rise_q.delete();
    push(16'h0026, 16'hBEEF, 1'b1);
    wait_idle();
    chk("w16_dones", dones - d0, 1);
    chk("w16_sb", sbq.size(), 0);
    chk("w16_writes", rise_q.size(), 2);
    if (rise_q.size() == 2)
      chk("w16_gap", rise_q[1] - rise_q[0], 6);
`endif

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end
endmodule
